// File: rtl/qam_pkg.sv
// Shared QAM definitions: IQ field layout, upsampler mode encodings, symbol type.
package qam_pkg;

  localparam int SYM_WIDTH = 32;
  localparam int I_MSB     = SYM_WIDTH - 1;
  localparam int I_LSB     = SYM_WIDTH / 2;
  localparam int Q_MSB     = SYM_WIDTH / 2 - 1;
  localparam int Q_LSB     = 0;

  typedef logic [SYM_WIDTH-1:0] qam_symbol_t;

  typedef enum logic {
    QAM_UPS_HOLD   = 1'b0,
    QAM_UPS_ZSTUFF = 1'b1
  } qam_ups_mode_e;

  function automatic qam_symbol_t qam_pack_iq(input logic [I_MSB-I_LSB:0] i_val,
                                              input logic [Q_MSB-Q_LSB:0] q_val);
    return {i_val, q_val};
  endfunction

endpackage

// File: rtl/qam_upsampler_if.sv
// Symbol-in / sample-out stream bundle of the QAM upsampler.
interface qam_upsampler_if
  import qam_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int RATIO_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]  signal_in;
  logic                   valid_in;
  logic                   ready_out;
  logic [RATIO_WIDTH-1:0] ratio;
  logic                   mode;
  logic [DATA_WIDTH-1:0]  signal_out;
  logic                   valid_out;
  logic                   ready_in;
  logic                   error;

  modport slave (
    input  signal_in, valid_in, ratio, mode, ready_in,
    output ready_out, signal_out, valid_out, error
  );

  modport master (
    output signal_in, valid_in, ratio, mode, ready_in,
    input  ready_out, signal_out, valid_out, error
  );
endinterface

// File: rtl/qam_skid_slot.sv
// Single-entry holding register for {symbol, ratio, mode} with load/unload/full.
module qam_skid_slot
  import qam_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int RATIO_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   unload,
  input  logic [DATA_WIDTH-1:0]  sym_d,
  input  logic [RATIO_WIDTH-1:0] ratio_d,
  input  qam_ups_mode_e          mode_d,
  output logic                   full,
  output logic [DATA_WIDTH-1:0]  sym_q,
  output logic [RATIO_WIDTH-1:0] ratio_q,
  output qam_ups_mode_e          mode_q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full    <= 1'b0;
      sym_q   <= '0;
      ratio_q <= '0;
      mode_q  <= QAM_UPS_HOLD;
    end else begin
      full <= load | (full & ~unload);
      if (load) begin
        sym_q   <= sym_d;
        ratio_q <= ratio_d;
        mode_q  <= mode_d;
      end
    end
  end

endmodule

// File: rtl/qam_upsampler.sv
// QAM symbol upsampler: emits ratio samples per accepted symbol (hold or zero-stuff),
// with a one-entry skid slot so ready_out can be registered.
module qam_upsampler
  import qam_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int RATIO_WIDTH = 4
) (
  input logic              clk,
  input logic              rst,
  qam_upsampler_if.slave   bus
);

  logic                   accept;
  logic                   last;
  logic                   advance;
  logic [RATIO_WIDTH-1:0] ratio_eff;
  qam_ups_mode_e          mode_in;

  logic [DATA_WIDTH-1:0]  cur_sym;
  logic [RATIO_WIDTH-1:0] cur_ratio;
  logic [RATIO_WIDTH-1:0] phase;
  qam_ups_mode_e          cur_mode;

  logic                   skid_full;
  logic                   skid_full_nx;
  logic                   skid_load;
  logic                   skid_unload;
  logic [DATA_WIDTH-1:0]  skid_sym;
  logic [RATIO_WIDTH-1:0] skid_ratio;
  qam_ups_mode_e          skid_mode;

  always_comb begin
    mode_in   = qam_ups_mode_e'(bus.mode);
    ratio_eff = (bus.ratio == '0) ? RATIO_WIDTH'(1) : bus.ratio;
    accept    = bus.valid_in && bus.ready_out;
    last      = (phase == cur_ratio - RATIO_WIDTH'(1));
    advance   = !bus.valid_out || (bus.ready_in && last);
    // Draining skid has priority; a same-cycle accept bypasses only when the skid is empty.
    skid_unload  = advance && skid_full;
    skid_load    = accept && !(advance && !skid_full);
    skid_full_nx = skid_load || (skid_full && !skid_unload);
  end

  qam_skid_slot #(
    .DATA_WIDTH  (DATA_WIDTH),
    .RATIO_WIDTH (RATIO_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .unload  (skid_unload),
    .sym_d   (bus.signal_in),
    .ratio_d (ratio_eff),
    .mode_d  (mode_in),
    .full    (skid_full),
    .sym_q   (skid_sym),
    .ratio_q (skid_ratio),
    .mode_q  (skid_mode)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.valid_out  <= 1'b0;
      bus.signal_out <= '0;
      bus.ready_out  <= 1'b0;
      bus.error      <= 1'b0;
      cur_sym        <= '0;
      cur_ratio      <= '0;
      cur_mode       <= QAM_UPS_HOLD;
      phase          <= '0;
    end else begin
      bus.ready_out <= !skid_full_nx;
      if (accept && bus.ratio == '0)
        bus.error <= 1'b1;

      if (advance) begin
        if (skid_full) begin
          cur_sym        <= skid_sym;
          cur_ratio      <= skid_ratio;
          cur_mode       <= skid_mode;
          bus.signal_out <= skid_sym;
          bus.valid_out  <= 1'b1;
          phase          <= '0;
        end else if (accept) begin
          cur_sym        <= bus.signal_in;
          cur_ratio      <= ratio_eff;
          cur_mode       <= mode_in;
          bus.signal_out <= bus.signal_in;
          bus.valid_out  <= 1'b1;
          phase          <= '0;
        end else begin
          bus.valid_out  <= 1'b0;
        end
      end else if (bus.ready_in) begin
        phase          <= phase + RATIO_WIDTH'(1);
        bus.signal_out <= (cur_mode == QAM_UPS_ZSTUFF) ? '0 : cur_sym;
      end
    end
  end

endmodule

// File: tb/tb_qam_upsampler.sv
// Directed self-checking bench for qam_upsampler.
module tb_qam_upsampler;
  import qam_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  qam_upsampler_if #(.DATA_WIDTH(32), .RATIO_WIDTH(4)) bus ();

  qam_upsampler #(.DATA_WIDTH(32), .RATIO_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] syms [4];
  logic [31:0] bp_pat;
  logic [31:0] p_sym;
  logic [31:0] q_sym;
  logic [31:0] zs_sym;
  int unsigned k;
  int unsigned si;
  int unsigned cyc;
  logic will_acc, will_xfer, stall;

  initial begin
    n_checks = 0;
    n_errors = 0;
    syms[0] = 32'h1111_2222;
    syms[1] = 32'h3333_4444;
    syms[2] = 32'h5555_AAAA;
    syms[3] = 32'hDEAD_BEEF;
    bp_pat  = 32'hB3A5_6C91;
    zs_sym  = qam_pack_iq(16'h7FFF, 16'h8000);

    // Reset with valid_in asserted
    rst = 1'b0;
    bus.valid_in  = 1'b1;
    bus.signal_in = 32'hCAFE_F00D;
    bus.ratio     = 4'd4;
    bus.mode      = 1'b0;
    bus.ready_in  = 1'b1;
    tick();
    tick();
    check("rst_valid", {31'd0, bus.valid_out}, 32'd0);
    check("rst_data",  bus.signal_out, 32'd0);
    check("rst_ready", {31'd0, bus.ready_out}, 32'd0);
    check("rst_error", {31'd0, bus.error}, 32'd0);
    bus.valid_in = 1'b0;
    rst = 1'b1;
    tick();
    check("ready_after_rst", {31'd0, bus.ready_out}, 32'd1);

    // Hold, R=4: two symbols, second waits in skid
    bus.valid_in  = 1'b1;
    bus.signal_in = 32'h0001_0002;
    tick();
    for (int i = 0; i < 8; i++) begin
      check("hold_valid", {31'd0, bus.valid_out}, 32'd1);
      check("hold_data", bus.signal_out, (i < 4) ? 32'h0001_0002 : 32'h0003_0004);
      check("hold_ready", {31'd0, bus.ready_out}, (i >= 1 && i <= 3) ? 32'd0 : 32'd1);
      if (i == 0) bus.signal_in = 32'h0003_0004;
      if (i == 1) bus.valid_in = 1'b0;
      tick();
    end
    check("hold_idle", {31'd0, bus.valid_out}, 32'd0);

    // Zero-stuff, R=3
    bus.ratio     = 4'd3;
    bus.mode      = 1'b1;
    bus.signal_in = zs_sym;
    bus.valid_in  = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    check("zs_p0", bus.signal_out, 32'h7FFF_8000);
    check("zs_v0", {31'd0, bus.valid_out}, 32'd1);
    tick();
    check("zs_p1", bus.signal_out, 32'd0);
    check("zs_v1", {31'd0, bus.valid_out}, 32'd1);
    tick();
    check("zs_p2", bus.signal_out, 32'd0);
    check("zs_v2", {31'd0, bus.valid_out}, 32'd1);
    tick();
    check("zs_idle", {31'd0, bus.valid_out}, 32'd0);

    // R=1 full-rate stream
    bus.ratio = 4'd1;
    bus.mode  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.signal_in = 32'hFFFF_FFFE - 32'(i);
      bus.valid_in  = 1'b1;
      tick();
      check("r1_ready", {31'd0, bus.ready_out}, 32'd1);
      check("r1_valid", {31'd0, bus.valid_out}, 32'd1);
      check("r1_data", bus.signal_out, 32'hFFFF_FFFE - 32'(i));
    end
    bus.valid_in = 1'b0;
    tick();
    check("r1_idle", {31'd0, bus.valid_out}, 32'd0);

    // Backpressure, R=2 hold: each symbol twice, output held while stalled
    bus.ratio = 4'd2;
    bus.mode  = 1'b0;
    k = 0; si = 0; cyc = 0;
    while (k < 8 && cyc < 300) begin
      bus.ready_in  = bp_pat[cyc % 32];
      bus.valid_in  = (si < 4);
      bus.signal_in = syms[si % 4];
      will_acc  = bus.valid_in && bus.ready_out;
      will_xfer = bus.valid_out && bus.ready_in;
      stall     = bus.valid_out && !bus.ready_in;
      if (bus.valid_out) check("bp_data", bus.signal_out, syms[k / 2]);
      tick();
      if (will_acc) si++;
      if (will_xfer) k++;
      if (stall) check("bp_hold_valid", {31'd0, bus.valid_out}, 32'd1);
      cyc++;
    end
    check("bp_samples", k, 32'd8);
    check("bp_accepted", si, 32'd4);
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;

    // Reset mid-symbol (p=1), then restart at p=0
    p_sym = 32'h0A0B_0C0D;
    bus.signal_in = p_sym;
    bus.valid_in  = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    check("mid_p0", bus.signal_out, p_sym);
    tick();
    check("mid_p1", bus.signal_out, p_sym);
    check("mid_v1", {31'd0, bus.valid_out}, 32'd1);
    bus.ready_in = 1'b0;
    rst = 1'b0;
    #1;
    check("async_valid", {31'd0, bus.valid_out}, 32'd0);
    check("async_data", bus.signal_out, 32'd0);
    check("async_ready", {31'd0, bus.ready_out}, 32'd0);
    tick();
    rst = 1'b1;
    bus.ready_in = 1'b1;
    tick();
    check("rerst_ready", {31'd0, bus.ready_out}, 32'd1);
    q_sym = 32'h1234_5678;
    bus.mode      = 1'b1;
    bus.signal_in = q_sym;
    bus.valid_in  = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    check("restart_p0", bus.signal_out, q_sym);
    check("restart_v0", {31'd0, bus.valid_out}, 32'd1);
    tick();
    check("restart_p1", bus.signal_out, 32'd0);
    check("restart_v1", {31'd0, bus.valid_out}, 32'd1);
    tick();
    check("restart_idle", {31'd0, bus.valid_out}, 32'd0);

    // ratio=0: one sample, sticky error
    check("err_clear", {31'd0, bus.error}, 32'd0);
    bus.ratio     = 4'd0;
    bus.mode      = 1'b0;
    bus.signal_in = 32'h0005_0006;
    bus.valid_in  = 1'b1;
    tick();
    bus.valid_in = 1'b0;
    check("r0_data", bus.signal_out, 32'h0005_0006);
    check("r0_valid", {31'd0, bus.valid_out}, 32'd1);
    check("r0_error", {31'd0, bus.error}, 32'd1);
    tick();
    check("r0_single", {31'd0, bus.valid_out}, 32'd0);
    check("r0_sticky1", {31'd0, bus.error}, 32'd1);
    tick();
    tick();
    check("r0_sticky2", {31'd0, bus.error}, 32'd1);
    rst = 1'b0;
    #1;
    check("r0_err_rst", {31'd0, bus.error}, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
